stack_unit: RTL and testbench

Hardware LIFO stack that services the push/pop requests issued by the CPU control unit (`psh`, `pop`, `CU_en`). It holds 16-bit operands (register spills, `ACC` saves) in an internal register array and returns popped data to the register write-back path. It is the responder for the control unit's stack interface. Every request is acknowledged with a one-cycle `done` pulse. Overflow and underflow are reported through sticky error flags.

---
 rtl/stack_unit.sv | 154 +++++++++++++++
 tb/tb_stack_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_unit.sv
`default_nettype none
// ============================================================================
//  Module   : stack_unit
//  Purpose  : LIFO operand stack answering the control unit's push, pop and
//             exchange requests, with a one-cycle done acknowledge and
//             sticky overflow/underflow flags.
//  Revision : 1.0  initial release
// ============================================================================
module stack_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             psh,
    input  logic             pop,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] tos,
    output logic [PTR_W:0]   sp,
    output logic             full,
    output logic             empty,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             unf
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_POP_RD = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    localparam logic [PTR_W:0]   c_sp_one  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   c_sp_full = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] c_idx_one = PTR_W'(1);

    state_t             state_q, state_d;
    logic [PTR_W:0]     sp_q, sp_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic               w_full;
    logic               w_empty;
    logic [PTR_W-1:0]   w_top_idx;
    logic               w_we;
    logic [PTR_W-1:0]   w_waddr;
    logic               w_ovf_set;
    logic               w_unf_set;

    // Occupancy flags and index of the current top entry. When sp == DEPTH the
    // low pointer bits are zero, so the wrapped subtraction still lands on DEPTH-1.
    assign w_full    = (sp_q == c_sp_full);
    assign w_empty   = (sp_q == '0);
    assign w_top_idx = sp_q[PTR_W-1:0] - c_idx_one;

    // Next-state, pointer, read-data and array-write decode.
    always_comb begin
        state_d   = state_q;
        sp_d      = sp_q;
        dout_d    = dout_q;
        w_we      = 1'b0;
        w_waddr   = sp_q[PTR_W-1:0];
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en && psh && !pop) begin
                    if (!w_full) begin
                        w_we  = 1'b1;
                        sp_d  = sp_q + c_sp_one;
                    end else begin
                        w_ovf_set = 1'b1;
                    end
                    state_d = S_ACK;
                end else if (en && pop && !psh) begin
                    if (!w_empty) begin
                        sp_d    = sp_q - c_sp_one;
                        state_d = S_POP_RD;
                    end else begin
                        w_unf_set = 1'b1;
                        state_d   = S_ACK;
                    end
                end else if (en && psh && pop) begin
                    // Exchange: old top leaves on data_out, new operand replaces it.
                    if (!w_empty) begin
                        dout_d  = mem_q[w_top_idx];
                        w_we    = 1'b1;
                        w_waddr = w_top_idx;
                    end else begin
                        w_unf_set = 1'b1;
                    end
                    state_d = S_ACK;
                end
            end
            S_POP_RD: begin
                // sp already points at the popped slot.
                dout_d  = mem_q[sp_q[PTR_W-1:0]];
                state_d = S_ACK;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A new error event wins over a simultaneous clear.
        ovf_d = w_ovf_set | (ovf_q & ~clr_err);
        unf_d = w_unf_set | (unf_q & ~clr_err);
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sp_q    <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage array is never cleared; a write is suppressed while reset is high.
    always_ff @(posedge clk) begin
        if (w_we && !rst) begin
            mem_q[w_waddr] <= data_in;
        end
    end

    assign data_out = dout_q;
    assign tos      = w_empty ? '0 : mem_q[w_top_idx];
    assign sp       = sp_q;
    assign full     = w_full;
    assign empty    = w_empty;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_ACK);
    assign ovf      = ovf_q;
    assign unf      = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_stack_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stack_unit
//  Purpose  : Directed self-checking bench for stack_unit (push, pop, LIFO
//             order, overflow, underflow, exchange, busy lockout, mid-pop reset).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_stack_unit;

    logic        clk = 1'b0;
    logic        rst, en, psh, pop, clr_err;
    logic [15:0] data_in, data_out, tos;
    logic [4:0]  sp;
    logic        full, empty, busy, done, ovf, unf;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done;

    stack_unit #(.WIDTH(16), .DEPTH(16), .PTR_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .psh      (psh),
        .pop      (pop),
        .clr_err  (clr_err),
        .data_in  (data_in),
        .data_out (data_out),
        .tos      (tos),
        .sp       (sp),
        .full     (full),
        .empty    (empty),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .unf      (unf)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and let outputs settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full push handshake: done in the cycle right after sampling.
    task automatic do_push(input logic [15:0] d);
        en = 1'b1; psh = 1'b1; pop = 1'b0; data_in = d;
        step();
        en = 1'b0; psh = 1'b0;
        check("push_done", done, 1);
        step();
    endtask

    // Full pop handshake: POP_RD then ACK with data_out valid.
    task automatic do_pop(input logic [15:0] exp_d);
        en = 1'b1; pop = 1'b1; psh = 1'b0;
        step();
        en = 1'b0; pop = 1'b0;
        check("pop_rd_nodone", done, 0);
        step();
        check("pop_done", done, 1);
        check("pop_data", data_out, exp_d);
        step();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; psh = 1'b0; pop = 1'b0; clr_err = 1'b0; data_in = '0;
        step();
        rst = 1'b0;

        // Reset state
        check("rst_sp", sp, 0);
        check("rst_dout", data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        check("rst_unf", unf, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_tos", tos, 0);

        // Single push and pop
        en = 1'b1; psh = 1'b1; data_in = 16'h1234;
        step();
        en = 1'b0; psh = 1'b0;
        check("p1_done", done, 1);
        check("p1_sp", sp, 1);
        check("p1_tos", tos, 16'h1234);
        step();
        check("p1_idle_done", done, 0);
        en = 1'b1; pop = 1'b1;
        step();
        en = 1'b0; pop = 1'b0;
        check("pop1_busy", busy, 1);
        check("pop1_done_early", done, 0);
        check("pop1_sp", sp, 0);
        step();
        check("pop1_done", done, 1);
        check("pop1_data", data_out, 16'h1234);
        check("pop1_empty", empty, 1);
        check("pop1_tos", tos, 0);
        step();

        // Fill, overflow, LIFO drain
        for (int i = 1; i <= 16; i++) do_push(16'(i));
        check("fill_full", full, 1);
        check("fill_sp", sp, 16);
        check("fill_tos", tos, 16);
        en = 1'b1; psh = 1'b1; data_in = 16'hFFFF;
        step();
        en = 1'b0; psh = 1'b0;
        check("ovf_done", done, 1);
        check("ovf_flag", ovf, 1);
        check("ovf_sp", sp, 16);
        check("ovf_tos", tos, 16);
        step();
        for (int i = 16; i >= 1; i--) do_pop(16'(i));
        check("drain_empty", empty, 1);
        check("drain_ovf_sticky", ovf, 1);

        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("ovf_clr", ovf, 0);

        // Underflow and clear
        en = 1'b1; pop = 1'b1;
        step();
        en = 1'b0; pop = 1'b0;
        check("unf_done", done, 1);
        check("unf_flag", unf, 1);
        check("unf_dout_hold", data_out, 1);
        check("unf_sp", sp, 0);
        step();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("unf_clr", unf, 0);
        en = 1'b1; pop = 1'b1; clr_err = 1'b1;
        step();
        en = 1'b0; pop = 1'b0; clr_err = 1'b0;
        check("unf_set_wins", unf, 1);
        check("unf_set_wins_done", done, 1);
        step();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("unf_clr2", unf, 0);

        // Exchange
        do_push(16'hAAAA);
        do_push(16'hBBBB);
        en = 1'b1; psh = 1'b1; pop = 1'b1; data_in = 16'hCCCC;
        step();
        en = 1'b0; psh = 1'b0; pop = 1'b0;
        check("xchg_done", done, 1);
        check("xchg_dout", data_out, 16'hBBBB);
        check("xchg_tos", tos, 16'hCCCC);
        check("xchg_sp", sp, 2);
        step();
        do_pop(16'hCCCC);
        do_pop(16'hAAAA);
        en = 1'b1; psh = 1'b1; pop = 1'b1; data_in = 16'hDDDD;
        step();
        en = 1'b0; psh = 1'b0; pop = 1'b0;
        check("xchg_e_done", done, 1);
        check("xchg_e_unf", unf, 1);
        check("xchg_e_sp", sp, 0);
        check("xchg_e_tos", tos, 0);
        check("xchg_e_dout", data_out, 16'hAAAA);
        step();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;

        // Busy lockout: push request in POP_RD is ignored
        do_push(16'h5555);
        do_push(16'h6666);
        n_done = 0;
        en = 1'b1; pop = 1'b1;
        step();
        pop = 1'b0; psh = 1'b1; data_in = 16'h7777;
        if (done) n_done++;
        step();
        en = 1'b0; psh = 1'b0;
        if (done) n_done++;
        check("lock_dout", data_out, 16'h6666);
        step();
        if (done) n_done++;
        step();
        if (done) n_done++;
        check("lock_done_count", n_done, 1);
        check("lock_sp", sp, 1);
        check("lock_tos", tos, 16'h5555);
        check("lock_busy", busy, 0);

        // Reset in POP_RD abandons the pop
        en = 1'b1; pop = 1'b1;
        step();
        en = 1'b0; pop = 1'b0;
        check("rmid_busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rmid_done", done, 0);
        check("rmid_sp", sp, 0);
        check("rmid_dout", data_out, 0);
        check("rmid_busy_after", busy, 0);
        step();
        check("rmid_done_later", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
